// File: rtl/io_pkg.sv
// Shared types and constants for the CPU IN-instruction controller.
// State encoding, opcodes and default debounce length.
package io_pkg;

    typedef enum logic [2:0] {
        OCIOSO           = 3'd0,
        ESPERA_SOLTA     = 3'd1,
        ESPERA_PRESSIONA = 3'd2,
        ENTREGA          = 3'd3,
        FIM              = 3'd4
    } estado_t;

    localparam logic [5:0] OPCODE_IN  = 6'b011101;
    localparam logic [5:0] OPCODE_OUT = 6'b011110;

    localparam logic [15:0] DEBOUNCE_PADRAO = 16'd50000;
    localparam int          LARGURA_PADRAO  = 16;

endpackage

// File: rtl/entrada_io_controlador_if.sv
// Board-pin and CPU-side signals of the IN controller.
// master is the controller, slave is the board/CPU side.
interface entrada_io_controlador_if;

    logic        botao_raw;
    logic [3:0]  chaves;
    logic        pedido_in;
    logic [31:0] dados_lidos;
    logic        dado_valido;
    logic        pausa;
    logic        ledin;

    modport master (
        input  botao_raw,
        input  chaves,
        input  pedido_in,
        output dados_lidos,
        output dado_valido,
        output pausa,
        output ledin
    );

    modport slave (
        output botao_raw,
        output chaves,
        output pedido_in,
        input  dados_lidos,
        input  dado_valido,
        input  pausa,
        input  ledin
    );

endinterface

// File: rtl/entrada_io_controlador_debounce_botao.sv
// Button synchroniser, debouncer and press-edge detector.
// estavel only changes after DEBOUNCE_CICLOS consecutive differing samples.
module debounce_botao
    import io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int          LARGURA_CONT    = LARGURA_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_raw,
    output logic estavel,
    output logic pressionado
);

    localparam logic [LARGURA_CONT-1:0] LIMITE =
        LARGURA_CONT'(DEBOUNCE_CICLOS - 16'd1);

    logic                    sinc_1;
    logic                    sinc_2;
    logic                    estavel_q;
    logic [LARGURA_CONT-1:0] cont;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_1 <= 1'b0;
            sinc_2 <= 1'b0;
        end else begin
            sinc_1 <= botao_raw;
            sinc_2 <= sinc_1;
        end
    end

    // Counter only runs while the input disagrees; it clears at LIMITE
    // when the level flips, so it can never pass LIMITE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont    <= '0;
            estavel <= 1'b0;
        end else if (sinc_2 != estavel) begin
            if (cont == LIMITE) begin
                cont    <= '0;
                estavel <= ~estavel;
            end else begin
                cont <= cont + 1'b1;
            end
        end else begin
            cont <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estavel_q <= 1'b0;
        end else begin
            estavel_q <= estavel;
        end
    end

    assign pressionado = estavel & ~estavel_q;

endmodule

// File: rtl/entrada_io_controlador.sv
// Producer side of the CPU IN instruction: stalls the CPU until a
// debounced button press captures the switches.
module entrada_io_controlador
    import io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int          LARGURA_CONT    = LARGURA_PADRAO
) (
    input logic                    clock,
    input logic                    reset,
    entrada_io_controlador_if.master io
);

    estado_t     estado;
    estado_t     prox;
    logic [3:0]  chaves_1;
    logic [3:0]  chaves_2;
    logic        estavel;
    logic        pressionado;
    logic        captura;
    logic [31:0] dados_q;

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .LARGURA_CONT    (LARGURA_CONT)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .botao_raw   (io.botao_raw),
        .estavel     (estavel),
        .pressionado (pressionado)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chaves_1 <= '0;
            chaves_2 <= '0;
        end else begin
            chaves_1 <= io.chaves;
            chaves_2 <= chaves_1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Dropping pedido_in while waiting aborts ahead of any press.
    always_comb begin
        prox           = estado;
        captura        = 1'b0;
        io.pausa       = 1'b0;
        io.ledin       = 1'b0;
        io.dado_valido = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (io.pedido_in) prox = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                io.pausa = 1'b1;
                io.ledin = 1'b1;
                if (!io.pedido_in)  prox = OCIOSO;
                else if (!estavel)  prox = ESPERA_PRESSIONA;
            end
            ESPERA_PRESSIONA: begin
                io.pausa = 1'b1;
                io.ledin = 1'b1;
                if (!io.pedido_in) begin
                    prox = OCIOSO;
                end else if (pressionado) begin
                    captura = 1'b1;
                    prox    = ENTREGA;
                end
            end
            ENTREGA: begin
                io.pausa       = 1'b1;
                io.dado_valido = 1'b1;
                prox           = FIM;
            end
            FIM: begin
                if (!io.pedido_in) prox = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dados_q <= '0;
        end else if (captura) begin
            dados_q <= {28'd0, chaves_2};
        end
    end

    assign io.dados_lidos = dados_q;

endmodule
